// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the core data port
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        rd_hit,
    output logic        tx,
    output logic        irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       count;
    logic             ovf;
    logic [15:0]      div;
    logic [15:0]      period;
    logic [15:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic        hit;
    logic [1:0]  offset;
    logic        full;
    logic        empty;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        bit_done;
    logic        frame_end;
    logic        next_idle;
    logic        ovf_clr;
    logic [4:0]  count_next;
    logic [15:0] div_eff;
    logic [31:0] status;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign hit       = (d_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = d_addr[3:2];
    assign full      = (count == 5'(FIFO_DEPTH));
    assign empty     = (count == 5'd0);
    assign push_req  = hit && (offset == 2'd0) && d_we[0];
    assign push      = push_req && !full;
    assign bit_done  = (bit_cnt == 16'd0);
    assign frame_end = (state == STOP) && bit_done;
    // Pops are decided purely from pre-edge occupancy, so a byte written this cycle cannot fall through.
    assign pop       = !empty && ((state == IDLE) || frame_end);
    assign next_idle = empty && ((state == IDLE) || frame_end);
    assign count_next = count + 5'(push) - 5'(pop);
    assign ovf_clr   = hit && (offset == 2'd1) && d_we[0] && d_wr_data[3];
    assign div_eff   = (div == 16'd0) ? 16'd1 : div;
    assign status    = {19'd0, count, 4'd0, ovf, (state != IDLE), empty, full};
    assign unused_bits = ^{d_addr[1:0], d_we[3:2], d_wr_data[31:16]};

    always_comb begin
        rd_val = 32'd0;
        if (hit) begin
            case (offset)
                2'd1:    rd_val = status;
                2'd2:    rd_val = {16'd0, div};
                default: rd_val = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 5'd0;
            ovf       <= 1'b0;
            div       <= DEFAULT_DIV;
            d_rd_data <= 32'd0;
            rd_hit    <= 1'b0;
        end else begin
            d_rd_data <= rd_val;
            rd_hit    <= hit;
            count     <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (hit && (offset == 2'd2)) begin
                if (d_we[0]) div[7:0]  <= d_wr_data[7:0];
                if (d_we[1]) div[15:8] <= d_wr_data[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            irq     <= 1'b1;
            period  <= 16'd1;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            irq <= (count_next == 5'd0) && next_idle;
            if (pop) begin
                // Period is sampled here so DIV writes mid-frame only affect later frames.
                shreg   <= mem[rd_ptr];
                period  <= div_eff;
                bit_cnt <= div_eff - 16'd1;
                state   <= START;
                tx      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (bit_done) begin
                            state   <= DATA;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= 3'd0;
                            bit_cnt <= period - 16'd1;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_done) begin
                            bit_cnt <= period - 16'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end else begin
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    STOP: begin
                        if (bit_done) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_DV = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        rd_hit;
    logic        tx;
    logic        irq;

    uart_tx_mmio #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(16),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk(clk),
        .rst(rst),
        .d_addr(d_addr),
        .d_we(d_we),
        .d_wr_data(d_wr_data),
        .d_rd_data(d_rd_data),
        .rd_hit(rd_hit),
        .tx(tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // bit32 set = compare the returned data, clear = window access whose data is not checked
    logic [32:0] rd_q[$];
    string       rd_n[$];
    logic [23:0] fr_q[$];
    int          starts[$];

    bit          in_frame = 1'b0;
    bit          fbad;
    bit          fskip;
    int          slot;
    int          scyc;
    int          fper;
    logic [7:0]  fbyte;
    logic [7:0]  rx_byte;
    logic        expb;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && rd_hit === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_hit=1 expected 0");
            end else begin
                logic [32:0] e;
                string       nm;
                e  = rd_q.pop_front();
                nm = rd_n.pop_front();
                if (e[32]) check(nm, d_rd_data, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                slot = 0;
                scyc = 0;
                fbad = 1'b0;
                rx_byte = 8'd0;
                starts.push_back(cyc);
                if (fr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got start bit at cycle %0d expected none", cyc);
                    fskip = 1'b1;
                    fper = 1;
                    fbyte = 8'd0;
                end else begin
                    logic [23:0] f;
                    f = fr_q.pop_front();
                    fskip = 1'b0;
                    fper = int'(f[23:8]);
                    fbyte = f[7:0];
                end
            end
            if (in_frame) begin
                expb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : fbyte[slot-1];
                if (tx !== expb) fbad = 1'b1;
                if (slot >= 1 && slot <= 8 && scyc == fper / 2) rx_byte[slot-1] = tx;
                scyc++;
                if (scyc == fper) begin
                    scyc = 0;
                    slot++;
                    if (slot == 10) begin
                        in_frame = 1'b0;
                        if (!fskip) check("frame", {23'd0, fbad, rx_byte}, {24'd0, fbyte});
                    end
                end
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input bit care, input logic [31:0] exp, input string nm);
        if (a[31:4] == BASE[31:4]) begin
            rd_q.push_back({care, exp});
            rd_n.push_back(nm);
        end
        d_addr = a;
        d_we = we;
        d_wr_data = wd;
        @(posedge clk);
        #1;
        d_addr = 32'd0;
        d_we = 4'd0;
        d_wr_data = 32'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        bus(a, we, wd, (a[3:2] == 2'd0), 32'd0, "txdata_reads_zero");
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus(a, 4'd0, 32'd0, 1'b1, exp, nm);
    endtask

    task automatic send(input logic [7:0] b, input int per);
        fr_q.push_back({16'(per), b});
        wr(A_TX, 4'b0001, {24'd0, b});
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int k = 0;
        while ((fr_q.size() != 0 || in_frame) && k < bound) begin
            @(posedge clk);
            k++;
        end
        check(nm, {31'd0, (k < bound)}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int lows;
        rst = 1'b0;
        d_addr = 32'd0;
        d_we = 4'd0;
        d_wr_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        check("reset_rd_hit", {31'd0, rd_hit}, 32'd0);
        check("reset_rd_data", d_rd_data, 32'd0);
        rd("reset_status", A_ST, 32'h0000_0002);
        rd("reset_div", A_DV, 32'h0000_0364);
        rd("txdata_read", A_TX, 32'd0);
        rd("reserved_read", A_RS, 32'd0);

        // single frame at DIV=4
        bus(A_DV, 4'b0011, 32'd4, 1'b0, 32'd0, "div_wr");
        send(8'h55, 4);
        repeat (5) @(posedge clk);
        #1;
        check("irq_busy", {31'd0, irq}, 32'd0);
        rd("status_busy", A_ST, 32'h0000_0006);
        wait_idle("frame_55_done", 200);
        check("irq_after", {31'd0, irq}, 32'd1);
        rd("status_idle", A_ST, 32'h0000_0002);

        // overflow and back-to-back frames
        starts.delete();
        for (int i = 0; i < 18; i++) begin
            if (i < 17) fr_q.push_back({16'd4, 8'(8'h10 + i)});
            wr(A_TX, 4'b0001, {24'd0, 8'(8'h10 + i)});
        end
        rd("status_full_ovf", A_ST, 32'h0000_100D);
        bus(A_ST, 4'b0001, 32'h8, 1'b0, 32'd0, "status_w1c");
        rd("status_ovf_cleared", A_ST, 32'h0000_1005);
        wait_idle("burst_done", 1000);
        check("burst_frames", starts.size(), 32'd17);
        if (starts.size() == 17) check("burst_span", starts[16] - starts[0], 32'd640);
        rd("status_after_burst", A_ST, 32'h0000_0002);

        // byte enables and divisor edge cases
        wr(A_TX, 4'b0010, 32'h0000_0077);
        rd("no_push_we1", A_ST, 32'h0000_0002);
        bus(A_DV, 4'b0010, 32'h0000_0100, 1'b0, 32'd0, "div_wr_hi");
        rd("div_hi_byte", A_DV, 32'h0000_0104);
        bus(A_DV, 4'b1111, 32'hFFFF_0000, 1'b0, 32'd0, "div_wr_zero");
        rd("div_zero", A_DV, 32'h0000_0000);
        send(8'h3C, 1);
        wait_idle("frame_div0_done", 100);

        // accesses just outside the window
        bus(BASE + 32'h10, 4'b1111, 32'h41, 1'b0, 32'd0, "out_hi");
        check("out_hi_rd_hit", {31'd0, rd_hit}, 32'd0);
        check("out_hi_rd_data", d_rd_data, 32'd0);
        bus(BASE - 32'h4, 4'b1111, 32'h42, 1'b0, 32'd0, "out_lo");
        check("out_lo_rd_hit", {31'd0, rd_hit}, 32'd0);
        check("out_lo_rd_data", d_rd_data, 32'd0);
        rd("status_after_out", A_ST, 32'h0000_0002);

        // reset in the middle of a frame
        bus(A_DV, 4'b0011, 32'd8, 1'b0, 32'd0, "div_wr8");
        send(8'hA5, 8);
        c0 = cyc;
        wr(A_TX, 4'b0001, 32'h01);
        wr(A_TX, 4'b0001, 32'h02);
        wr(A_TX, 4'b0001, 32'h03);
        while (cyc < c0 + 30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        fr_q.delete();
        rd_q.delete();
        rd_n.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        rd("post_reset_status", A_ST, 32'h0000_0002);
        rd("post_reset_div", A_DV, 32'h0000_0364);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("post_reset_quiet", lows, 32'd0);
        check("post_reset_irq", {31'd0, irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that sits directly downstream of the core's data port (d_addr/d_we/d_wr_data/d_rd_data), beside data RAM. It consumes store traffic addressed to its window, buffers bytes in a TX FIFO and serializes them 8N1 on a single pin. Loads to the window return status or divisor with the same one-cycle registered read latency as data RAM, so the top-level read mux selects on rd_hit.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; 16-byte window, decode on d_addr[31:4]
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..16
DEFAULT_DIV, 16'd868, reset bit period in clk cycles (100 MHz / 115200)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (low = reset)
d_addr  input  32  core data address
d_we  input  4  core byte write enables
d_wr_data  input  32  core store data
d_rd_data  output  32  registered read data
rd_hit  output  1  registered: previous-cycle d_addr was in window
tx  output  1  serial out, idle high
irq  output  1  registered: FIFO empty and serializer idle

Behaviour:
- Reset (async, rst low): tx=1, d_rd_data=0, rd_hit=0, irq=1, FIFO empty, DIV=DEFAULT_DIV, ovf=0, FSM=IDLE. Mid-frame reset: tx goes high immediately; the frame is abandoned.
- hit = (d_addr[31:4]==BASE_ADDR[31:4]); offset = d_addr[3:2]. Outside the window: no side effects, rd_hit=0 next cycle.
- Register map:
  - +0x0 TXDATA (W): hit & offset 0 & d_we[0] pushes d_wr_data[7:0]. Reads as 0.
  - +0x4 STATUS (R/W1C): bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bit3 ovf (sticky), [12:8] FIFO count, other bits 0. A write with d_we[0] and d_wr_data[3]=1 clears ovf.
  - +0x8 DIV (R/W): [15:0]; d_we[0] writes [7:0], d_we[1] writes [15:8]; upper bytes are ignored and read 0.
  - +0xC: reads 0, writes ignored.
- Reads: every cycle d_rd_data <= hit ? reg[offset] : 0, and rd_hit <= hit. Reads have no side effects. Latency is 1 cycle.
- Push to a full FIFO drops the byte and sets ovf. Fullness is judged before the edge, so a same-cycle pop does not admit the push. A push at the same edge as ovf is cleared leaves ovf=1.
- Pop occurs only when the FIFO is non-empty before the edge; there is no fall-through.
- Serializer FSM (IDLE, START, DATA, STOP):
  - bit counter counts down from period-1; period = max(DIV,1), latched at frame start. DIV writes mid-frame affect the next frame only.
  - IDLE: if FIFO non-empty, pop into the shift register and go to START.
  - START: tx=0 for period cycles.
  - DATA: 8 bits, LSB first, period cycles each.
  - STOP: tx=1 for period cycles. At the end, go to START (pop) if the FIFO is non-empty, else IDLE.
  - Frame length is exactly 10*period cycles. Back-to-back frames have no idle gap.
- tx is registered. A TXDATA write captured at edge E0 into an idle, empty block drives tx low from edge E1.
- irq <= empty & (next FSM == IDLE). It is a level, not a pulse.

Test Plan:
- Reset then read STATUS and DIV -> tx=1, irq=1, STATUS=0x0000_0002, DIV=0x0000_0364, rd_hit=1 one cycle after each read.
- Write DIV=4, then TXDATA=0x55 -> tx low from E1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high 4 cycles. Frame is 40 cycles, irq low during the frame and 1 after; STATUS busy=1 during.
- DIV=4, 18 consecutive TXDATA writes -> first byte popped at E1, 16 buffered; 18th dropped. STATUS shows full=1, ovf=1, count=16. Write STATUS 0x8 -> ovf=0, and exactly 17 frames are emitted back-to-back in 680 cycles.
- Byte enables: d_we=4'b0010 to TXDATA -> no push. d_we=4'b0010 data 0x0000_0100 to DIV after DIV=4 -> DIV=0x0104. Write DIV=0 -> frames use a 1-cycle period (10-cycle frame).
- Write to BASE_ADDR+0x10 and BASE_ADDR-4 -> no push, rd_hit=0, d_rd_data=0.
- DIV=8, byte 0xA5 plus 3 queued, assert rst low at cycle 30 -> tx=1 the same cycle asynchronously. After release: STATUS=0x2, DIV=868, no further frames.
